// File: rtl/trena_uc.sv
// Control unit for the tape-measure datapath: runs one HC-SR04 measurement, sends it as
// three hex characters plus "#", and adds a timeout and an optional continuous mode.
module trena_uc #(
    parameter int TIMEOUT = 2500000,
    parameter int PERIODO = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       medir,
    input  logic       modo_continuo,
    input  logic       fim_medida,
    input  logic       fim_digito,
    input  logic       fim_envio,
    output logic       zera,
    output logic       mensurar,
    output logic       conta,
    output logic       partida,
    output logic       pronto,
    output logic       erro,
    output logic [3:0] db_estado
);

    localparam int MAXC = (TIMEOUT > PERIODO) ? TIMEOUT : PERIODO;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARACAO     = 4'd1,
        MEDIDA         = 4'd2,
        AGUARDA_MEDIDA = 4'd3,
        TRANSMITE      = 4'd4,
        ESPERA_TX      = 4'd5,
        PROXIMO        = 4'd6,
        FINAL          = 4'd7,
        ESPERA_PERIODO = 4'd8,
        ERRO           = 4'd14
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= INICIAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any state change restarts the counter, so it reads 0 on the first cycle of a wait state.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == AGUARDA_MEDIDA || state_q == ESPERA_PERIODO) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INICIAL:        if (medir || modo_continuo) state_d = PREPARACAO;
            PREPARACAO:     state_d = MEDIDA;
            MEDIDA:         state_d = AGUARDA_MEDIDA;
            AGUARDA_MEDIDA: begin
                if (fim_medida) begin
                    state_d = TRANSMITE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = ERRO;
                end
            end
            TRANSMITE:      state_d = ESPERA_TX;
            ESPERA_TX:      if (fim_digito) state_d = fim_envio ? FINAL : PROXIMO;
            PROXIMO:        state_d = TRANSMITE;
            FINAL:          state_d = modo_continuo ? ESPERA_PERIODO : INICIAL;
            ESPERA_PERIODO: begin
                if (!modo_continuo) begin
                    state_d = INICIAL;
                end else if (cnt_q == CW'(PERIODO - 1)) begin
                    state_d = PREPARACAO;
                end
            end
            ERRO:           state_d = modo_continuo ? ESPERA_PERIODO : INICIAL;
            default:        state_d = INICIAL;
        endcase
    end

    always_comb begin
        zera      = 1'b0;
        mensurar  = 1'b0;
        conta     = 1'b0;
        partida   = 1'b0;
        pronto    = 1'b0;
        erro      = 1'b0;
        db_estado = state_q;
        case (state_q)
            PREPARACAO: zera     = 1'b1;
            MEDIDA:     mensurar = 1'b1;
            TRANSMITE:  partida  = 1'b1;
            PROXIMO:    conta    = 1'b1;
            FINAL:      pronto   = 1'b1;
            ERRO:       erro     = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_trena_uc.sv
// Bench for trena_uc: models the HC-SR04 interface, the serial TX and the digit counter,
// and compares the observed control pulse sequence and timing against expected queues.
module tb_trena_uc;

    localparam int TIMEOUT = 100;
    localparam int PERIODO = 50;
    localparam int TXDLY   = 10;

    localparam int EV_ZERA = 1, EV_MENS = 2, EV_PART = 3, EV_CONTA = 4, EV_PRONTO = 5, EV_ERRO = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       medir = 1'b0;
    logic       modo_continuo = 1'b0;
    logic       fim_medida, fim_digito, fim_envio;
    logic       zera, mensurar, conta, partida, pronto, erro;
    logic [3:0] db_estado;

    logic modelMed = 1'b0, modelDig = 1'b0, strayMed = 1'b0, strayDig = 1'b0;
    int   sel = 0, cyc = 0, medTimer = 0, digTimer = 0;
    int   measDelay = 20, txDelay = TXDLY;
    int   medirCyc = 0;
    int   checks = 0, failures = 0;

    typedef struct {
        int code;
        int cyc;
    } ev_t;

    ev_t obsQ[$];
    int  expQ[$];

    assign fim_medida = modelMed | strayMed;
    assign fim_digito = modelDig | strayDig;
    assign fim_envio  = (sel == 3);

    trena_uc #(.TIMEOUT(TIMEOUT), .PERIODO(PERIODO)) dut (
        .clock         (clock),
        .reset         (reset),
        .medir         (medir),
        .modo_continuo (modo_continuo),
        .fim_medida    (fim_medida),
        .fim_digito    (fim_digito),
        .fim_envio     (fim_envio),
        .zera          (zera),
        .mensurar      (mensurar),
        .conta         (conta),
        .partida       (partida),
        .pronto        (pronto),
        .erro          (erro),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    function automatic void logEvent(input int code);
        ev_t e;
        e.code = code;
        e.cyc  = cyc;
        obsQ.push_back(e);
    endfunction

    // Environment model: sensor, serial TX and digit counter react to the DUT's pulses.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            modelMed = 1'b0;
            modelDig = 1'b0;
            if (reset) begin
                sel = 0;
                medTimer = 0;
                digTimer = 0;
            end else begin
                if (medTimer > 0) begin
                    medTimer--;
                    if (medTimer == 0) modelMed = 1'b1;
                end
                if (digTimer > 0) begin
                    digTimer--;
                    if (digTimer == 0) modelDig = 1'b1;
                end
                if (zera) begin logEvent(EV_ZERA); sel = 0; end
                if (mensurar) begin logEvent(EV_MENS); if (measDelay > 0) medTimer = measDelay; end
                if (partida) begin logEvent(EV_PART); digTimer = txDelay; end
                if (conta) begin logEvent(EV_CONTA); sel++; end
                if (pronto) logEvent(EV_PRONTO);
                if (erro) logEvent(EV_ERRO);
            end
        end
    end

    task automatic waitEvents(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock); #1;
            if (obsQ.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulseMedir();
        @(negedge clock); #1;
        medir = 1'b1;
        medirCyc = cyc;
        @(negedge clock); #1;
        medir = 1'b0;
    endtask

    task automatic pushMeasurement();
        expQ.push_back(EV_ZERA);
        expQ.push_back(EV_MENS);
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(EV_PART);
            expQ.push_back(EV_CONTA);
        end
        expQ.push_back(EV_PART);
        expQ.push_back(EV_PRONTO);
    endtask

    task automatic test_reset();
        bit ok;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if ({zera, mensurar, conta, partida, pronto, erro, db_estado} !== 10'd0) begin
            failures++;
            $display("[TB] FAIL reset_state got=%b want=0", {zera, mensurar, conta, partida, pronto, erro, db_estado});
        end
        reset = 1'b0;
        obsQ.delete();
        measDelay = 20;
        txDelay = 1000;
        pulseMedir();
        waitEvents(3, 200, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_reach_tx got=%0d events want=3", obsQ.size());
        end
        repeat (5) @(negedge clock);
        #1;
        checks++;
        if (db_estado !== 4'd5) begin
            failures++;
            $display("[TB] FAIL reset_in_espera_tx got=%0d want=5", db_estado);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({zera, mensurar, conta, partida, pronto, erro, db_estado} !== 10'd0) begin
            failures++;
            $display("[TB] FAIL reset_async got=%b want=0", {zera, mensurar, conta, partida, pronto, erro, db_estado});
        end
        @(negedge clock); #1;
        reset = 1'b0;
        txDelay = TXDLY;
        obsQ.delete();
        repeat (60) @(negedge clock);
        #1;
        checks++;
        if (obsQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL reset_no_activity got=%0d events want=0", obsQ.size());
        end
    endtask

    task automatic test_single();
        bit  ok;
        ev_t got[$];
        obsQ.delete();
        expQ.delete();
        measDelay = 20;
        pushMeasurement();
        pulseMedir();
        waitEvents(10, 300, ok);
        repeat (20) @(negedge clock);
        #1;
        got = obsQ;
        for (int i = 0; i < expQ.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i].code !== expQ[i]) begin
                failures++;
                $display("[TB] FAIL single_seq[%0d] got=%0d want=%0d", i, (i < got.size()) ? got[i].code : -1, expQ[i]);
            end
        end
        checks++;
        if (got.size() !== expQ.size()) begin
            failures++;
            $display("[TB] FAIL single_count got=%0d want=%0d", got.size(), expQ.size());
        end
        if (got.size() >= 10) begin
            checks++;
            if (got[1].cyc - medirCyc !== 2) begin
                failures++;
                $display("[TB] FAIL lat_medir_mensurar got=%0d want=2", got[1].cyc - medirCyc);
            end
            checks++;
            if (got[2].cyc - got[1].cyc !== 21) begin
                failures++;
                $display("[TB] FAIL lat_mensurar_partida got=%0d want=21", got[2].cyc - got[1].cyc);
            end
            checks++;
            if (got[4].cyc - got[2].cyc !== TXDLY + 2) begin
                failures++;
                $display("[TB] FAIL lat_partida_partida got=%0d want=%0d", got[4].cyc - got[2].cyc, TXDLY + 2);
            end
            checks++;
            if (got[9].cyc - got[8].cyc !== TXDLY + 1) begin
                failures++;
                $display("[TB] FAIL lat_last_pronto got=%0d want=%0d", got[9].cyc - got[8].cyc, TXDLY + 1);
            end
        end
        checks++;
        if (db_estado !== 4'd0) begin
            failures++;
            $display("[TB] FAIL single_end_state got=%0d want=0", db_estado);
        end
    endtask

    task automatic test_timeout();
        bit  ok;
        ev_t got[$];
        obsQ.delete();
        expQ.delete();
        measDelay = 0;
        expQ.push_back(EV_ZERA);
        expQ.push_back(EV_MENS);
        expQ.push_back(EV_ERRO);
        pulseMedir();
        waitEvents(3, 300, ok);
        repeat (20) @(negedge clock);
        #1;
        got = obsQ;
        for (int i = 0; i < expQ.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i].code !== expQ[i]) begin
                failures++;
                $display("[TB] FAIL timeout_seq[%0d] got=%0d want=%0d", i, (i < got.size()) ? got[i].code : -1, expQ[i]);
            end
        end
        checks++;
        if (got.size() !== 3) begin
            failures++;
            $display("[TB] FAIL timeout_count got=%0d want=3", got.size());
        end
        checks++;
        if (got.size() >= 3 && got[2].cyc - got[1].cyc !== TIMEOUT + 1) begin
            failures++;
            $display("[TB] FAIL timeout_latency got=%0d want=%0d", got[2].cyc - got[1].cyc, TIMEOUT + 1);
        end
        checks++;
        if (db_estado !== 4'd0) begin
            failures++;
            $display("[TB] FAIL timeout_end_state got=%0d want=0", db_estado);
        end

        // fim_medida lands on the very cycle the counter hits TIMEOUT-1.
        obsQ.delete();
        expQ.delete();
        measDelay = TIMEOUT;
        pushMeasurement();
        pulseMedir();
        waitEvents(10, 400, ok);
        repeat (20) @(negedge clock);
        #1;
        got = obsQ;
        for (int i = 0; i < expQ.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i].code !== expQ[i]) begin
                failures++;
                $display("[TB] FAIL edge_seq[%0d] got=%0d want=%0d", i, (i < got.size()) ? got[i].code : -1, expQ[i]);
            end
        end
        checks++;
        if (got.size() !== expQ.size()) begin
            failures++;
            $display("[TB] FAIL edge_count got=%0d want=%0d", got.size(), expQ.size());
        end
        checks++;
        if (got.size() >= 3 && got[2].cyc - got[1].cyc !== TIMEOUT + 1) begin
            failures++;
            $display("[TB] FAIL edge_latency got=%0d want=%0d", got[2].cyc - got[1].cyc, TIMEOUT + 1);
        end
        measDelay = 20;
    endtask

    task automatic test_continuous();
        bit  ok;
        ev_t got[$];
        obsQ.delete();
        expQ.delete();
        measDelay = 20;
        pushMeasurement();
        pushMeasurement();
        @(negedge clock); #1;
        modo_continuo = 1'b1;
        waitEvents(20, 1000, ok);
        got = obsQ;
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cont_wait got=%0d events want=20", obsQ.size());
        end
        for (int i = 0; i < expQ.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i].code !== expQ[i]) begin
                failures++;
                $display("[TB] FAIL cont_seq[%0d] got=%0d want=%0d", i, (i < got.size()) ? got[i].code : -1, expQ[i]);
            end
        end
        checks++;
        if (got.size() >= 11 && got[10].cyc - got[9].cyc !== PERIODO + 1) begin
            failures++;
            $display("[TB] FAIL cont_period got=%0d want=%0d", got[10].cyc - got[9].cyc, PERIODO + 1);
        end
        repeat (10) @(negedge clock);
        #1;
        checks++;
        if (db_estado !== 4'd8) begin
            failures++;
            $display("[TB] FAIL cont_in_espera got=%0d want=8", db_estado);
        end
        modo_continuo = 1'b0;
        @(negedge clock); #1;
        checks++;
        if (db_estado !== 4'd0) begin
            failures++;
            $display("[TB] FAIL cont_drop got=%0d want=0", db_estado);
        end
        repeat (60) @(negedge clock);
        #1;
        checks++;
        if (obsQ.size() !== 20) begin
            failures++;
            $display("[TB] FAIL cont_quiet got=%0d events want=20", obsQ.size());
        end
    endtask

    task automatic test_busy();
        bit  ok;
        int  nPart, nConta;
        ev_t got[$];
        obsQ.delete();
        expQ.delete();
        measDelay = 20;
        pushMeasurement();
        pulseMedir();
        for (int k = 0; k < 2; k++) begin
            repeat (4) @(negedge clock);
            #1;
            strayDig = 1'b1;
            @(negedge clock); #1;
            strayDig = 1'b0;
        end
        waitEvents(3, 200, ok);
        for (int k = 0; k < 3; k++) begin
            repeat (10) @(negedge clock);
            #1;
            medir = 1'b1;
            strayMed = 1'b1;
            @(negedge clock); #1;
            medir = 1'b0;
            strayMed = 1'b0;
        end
        waitEvents(10, 300, ok);
        repeat (40) @(negedge clock);
        #1;
        got = obsQ;
        nPart = 0;
        nConta = 0;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i].code == EV_PART) nPart++;
            if (got[i].code == EV_CONTA) nConta++;
        end
        for (int i = 0; i < expQ.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i].code !== expQ[i]) begin
                failures++;
                $display("[TB] FAIL busy_seq[%0d] got=%0d want=%0d", i, (i < got.size()) ? got[i].code : -1, expQ[i]);
            end
        end
        checks++;
        if (nPart !== 4 || nConta !== 3 || got.size() !== expQ.size()) begin
            failures++;
            $display("[TB] FAIL busy_counts got=%0d/%0d/%0d want=4/3/%0d", nPart, nConta, got.size(), expQ.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_continuous();
        test_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
